// File: rtl/roll_history_display_if.sv
// Bundle between the dice generator/keys and the roll history display.
// master: drives the roll value, rolling flag and key pulses; observes display/status.
// slave:  the display block; consumes inputs, drives segments and browse status.
interface roll_history_display_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [3:0]    i_random_num;
    logic          i_changing;
    logic          i_prev;
    logic          i_next;
    logic          i_clear;
    logic [6:0]    o_seven_hi;
    logic [6:0]    o_seven_lo;
    logic          o_browsing;
    logic [IW-1:0] o_index;
    logic [CW-1:0] o_count;

    modport master (
        output i_random_num, i_changing, i_prev, i_next, i_clear,
        input  o_seven_hi, o_seven_lo, o_browsing, o_index, o_count
    );

    modport slave (
        input  i_random_num, i_changing, i_prev, i_next, i_clear,
        output o_seven_hi, o_seven_lo, o_browsing, o_index, o_count
    );
endinterface

// File: rtl/roll_history_display.sv
// Roll history display: shows the live roll as two active-low 7-segment digits
// (00-15), records each settled roll in a circular buffer, and lets the user
// browse older rolls with prev/next pulses.
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   bus        slave modport: i_random_num, i_changing, i_prev, i_next, i_clear in;
//              o_seven_hi, o_seven_lo, o_browsing, o_index, o_count out
module roll_history_display #(
    parameter int unsigned DEPTH = 8
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    roll_history_display_if.slave  bus
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    typedef enum logic {
        S_LIVE   = 1'b0,
        S_BROWSE = 1'b1
    } state_t;

    state_t        state_q, state_nxt;
    logic [IW-1:0] wr_ptr_q, wr_ptr_nxt;
    logic [CW-1:0] count_q, count_nxt;
    logic [IW-1:0] offset_q, offset_nxt;
    logic          chg_d_q;
    logic [6:0]    seg_hi_q, seg_hi_nxt;
    logic [6:0]    seg_lo_q, seg_lo_nxt;
    logic [3:0]    mem_q [DEPTH];

    logic          mem_we;
    logic          capture;
    logic [IW-1:0] rd_idx;
    logic [3:0]    sel_val;
    logic          tens;
    logic [3:0]    units;

    // Active-low gfedcba pattern for a decimal digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state, history bookkeeping and display selection
    always_comb begin
        state_nxt  = state_q;
        wr_ptr_nxt = wr_ptr_q;
        count_nxt  = count_q;
        offset_nxt = offset_q;
        mem_we     = 1'b0;

        // A settled roll is the first low sample of i_changing after a high one
        capture = chg_d_q & ~bus.i_changing;

        if (bus.i_clear) begin
            state_nxt  = S_LIVE;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
            offset_nxt = '0;
        end else if (capture) begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr_q + IW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_nxt = count_q + CW'(1);
            end
            state_nxt  = S_LIVE;
            offset_nxt = '0;
        end else if (bus.i_changing) begin
            state_nxt  = S_LIVE;
            offset_nxt = '0;
        end else if (bus.i_prev ^ bus.i_next) begin
            case (state_q)
                S_LIVE: begin
                    if (bus.i_prev && (count_q != '0)) begin
                        state_nxt  = S_BROWSE;
                        offset_nxt = '0;
                    end
                end
                S_BROWSE: begin
                    if (bus.i_prev) begin
                        // Saturate at the oldest stored entry
                        if (CW'(offset_q) < (count_q - CW'(1))) begin
                            offset_nxt = offset_q + IW'(1);
                        end
                    end else if (offset_q != '0) begin
                        offset_nxt = offset_q - IW'(1);
                    end else begin
                        state_nxt = S_LIVE;
                    end
                end
                default: state_nxt = S_LIVE;
            endcase
        end

        // Newest stored entry sits just behind the write pointer
        rd_idx  = wr_ptr_q - IW'(1) - offset_q;
        sel_val = (state_q == S_BROWSE) ? mem_q[rd_idx] : bus.i_random_num;
        tens    = (sel_val >= 4'd10);
        units   = tens ? (sel_val - 4'd10) : sel_val;

        seg_hi_nxt = seg7(tens ? 4'd1 : 4'd0);
        seg_lo_nxt = seg7(units);
    end

    // Control and display registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_LIVE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            offset_q <= '0;
            chg_d_q  <= 1'b0;
            seg_hi_q <= 7'b1000000;
            seg_lo_q <= 7'b1000000;
        end else begin
            state_q  <= state_nxt;
            wr_ptr_q <= wr_ptr_nxt;
            count_q  <= count_nxt;
            offset_q <= offset_nxt;
            chg_d_q  <= bus.i_changing;
            seg_hi_q <= seg_hi_nxt;
            seg_lo_q <= seg_lo_nxt;
        end
    end

    // History storage; contents are only read once count covers them, so no reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.i_random_num;
        end
    end

    assign bus.o_seven_hi = seg_hi_q;
    assign bus.o_seven_lo = seg_lo_q;
    assign bus.o_browsing = (state_q == S_BROWSE);
    assign bus.o_index    = offset_q;
    assign bus.o_count    = count_q;

endmodule
